// File: rtl/spin_driver.sv
// rtl/spin_driver.sv - command FIFO and FSM that sequences the spinner rotator
// Each command is rotated right by amount, count times, via the rotator's recirculation path.
module spin_driver #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic [4:0]  cmd_amount,
  input  logic [3:0]  cmd_count,
  output logic [31:0] rot_din,
  output logic [4:0]  rot_amount,
  output logic        rot_spin,
  input  logic [31:0] rot_dout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SPIN, S_CAPTURE, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [40:0] fifo_mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full, push, pop;
  logic [40:0] head;
  logic [31:0] d_q, d_d;
  logic [4:0]  a_q, a_d;
  logic [3:0]  n_q, n_d, r_q, r_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {cmd_data, cmd_amount, cmd_count};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    a_d         = a_q;
    n_d         = n_q;
    r_d         = r_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    rot_din     = 32'd0;
    rot_spin    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !res_valid_q) begin
          pop     = 1'b1;
          d_d     = head[40:9];
          a_d     = head[8:4];
          n_d     = (head[3:0] == 4'd0) ? 4'd1 : head[3:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rot_din  = d_q;
        rot_spin = (n_q > 4'd1);
        r_d      = n_q - 4'd1;
        state_d  = (n_q > 4'd1) ? S_SPIN : S_CAPTURE;
      end
      S_SPIN: begin
        // Spin drops on the final pass so the rotator is not recirculating in CAPTURE.
        rot_din  = d_q;
        rot_spin = (r_q > 4'd1);
        r_d      = r_q - 4'd1;
        if (r_q <= 4'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_data_d  = rot_dout;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      d_q         <= '0;
      a_q         <= '0;
      n_q         <= '0;
      r_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      a_q         <= a_d;
      n_q         <= n_d;
      r_q         <= r_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Amount is only updated on pop, so it holds its last value while idle.
  assign rot_amount = a_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

endmodule
